// File: rtl/exc_ctrl.sv
// Exception/stall controller: freezes the pipeline on an exception, emits a
// one-cycle flush with the redirect PC, arbitrates stage stalls and flags interrupts.
//
// state | meaning
// IDLE  | normal flow, watching for exceptions and stall requests
// FLUSH | flush_o pulse with the latched redirect PC
// HOLD  | one settling cycle, exceptions ignored
module exc_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
   parameter logic [7:0]  STALL_MAX  = 8'd64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_id_i,
   input  logic        stallreq_ex_i,
   input  logic [31:0] exception_type_i,
   input  logic [31:0] cp0_status_i,
   input  logic [31:0] cp0_cause_i,
   input  logic [31:0] cp0_epc_i,
   output logic [5:0]  stall_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o,
   output logic        int_pending_o,
   output logic [2:0]  int_line_o,
   output logic        stall_timeout_o
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FLUSH = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;
   localparam logic [31:0] EXC_ERET = 32'h0000_000e;

   logic [1:0]  state;
   logic [31:0] target;
   logic [7:0]  stall_cnt;
   logic        timeout_q;
   logic        exc_hit;
   logic        run_stall;
   logic [5:0]  req_stall;
   logic [7:0]  pending;
   logic        unused_ok;

   assign exc_hit = (state == IDLE) && (exception_type_i != 32'd0);

   always_comb begin
      req_stall = 6'b000000;
      if (stallreq_ex_i)
         req_stall = 6'b001111;
      else if (stallreq_id_i)
         req_stall = 6'b000111;
   end

   assign run_stall = (state == IDLE) && !exc_hit && (req_stall != 6'b000000);

   always_comb begin
      stall_o = 6'b000000;
      if (!rst) begin
         if (exc_hit)
            stall_o = 6'b111111;
         else if (state == IDLE)
            stall_o = req_stall;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         target    <= 32'd0;
         stall_cnt <= 8'd0;
         timeout_q <= 1'b0;
      end else begin
         case (state)
            IDLE: if (exc_hit) begin
               state  <= FLUSH;
               target <= (exception_type_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
            end
            FLUSH:   state <= HOLD;
            default: state <= IDLE;
         endcase
         // any cycle without an IDLE stall request breaks the run
         if (run_stall)
            stall_cnt <= (stall_cnt == 8'hff) ? 8'hff : stall_cnt + 8'd1;
         else
            stall_cnt <= 8'd0;
         if (stall_cnt == STALL_MAX)
            timeout_q <= 1'b1;
      end
   end

   assign flush_o         = (state == FLUSH);
   assign new_pc_o        = flush_o ? target : 32'd0;
   assign stall_timeout_o = timeout_q | (stall_cnt == STALL_MAX);

   assign pending = cp0_cause_i[15:8] & cp0_status_i[15:8];

   always_comb begin
      int_line_o = 3'd0;
      if (!rst) begin
         for (int i = 0; i < 8; i++)
            if (pending[i])
               int_line_o = 3'(i);
      end
   end

   assign int_pending_o = !rst && (|pending) && cp0_status_i[0] && !cp0_status_i[1];

   assign unused_ok = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                        cp0_cause_i[31:16], cp0_cause_i[7:0]};

endmodule

// File: tb/tb_exc_ctrl.sv
// Testbench for exc_ctrl: directed vector table, watchdog sequence and
// randomized traffic, all checked against a cycle-level reference model.
module tb_exc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallreq_id_i, stallreq_ex_i;
   logic [31:0] exception_type_i, cp0_status_i, cp0_cause_i, cp0_epc_i;
   logic [5:0]  stall_o;
   logic        flush_o;
   logic [31:0] new_pc_o;
   logic        int_pending_o;
   logic [2:0]  int_line_o;
   logic        stall_timeout_o;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: sequence phase (0 idle, 1 flush, 2 hold), target, stall run, sticky flag
   int          m_phase;
   logic [31:0] m_tgt;
   int          m_run;
   bit          m_sticky;

   exc_ctrl dut (
      .clk(clk), .rst(rst),
      .stallreq_id_i(stallreq_id_i), .stallreq_ex_i(stallreq_ex_i),
      .exception_type_i(exception_type_i),
      .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
      .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
      .int_pending_o(int_pending_o), .int_line_o(int_line_o),
      .stall_timeout_o(stall_timeout_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, id, ex;
      logic [31:0] exc, status, cause, epc;
      logic [5:0]  e_stall;
      logic        e_flush;
      logic [31:0] e_pc;
      logic        e_ip;
      logic [2:0]  e_line;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_check();
      logic [7:0]  pend;
      logic [5:0]  e_stall;
      logic        e_ip;
      logic [2:0]  e_line;
      pend    = cp0_cause_i[15:8] & cp0_status_i[15:8];
      e_stall = 6'd0;
      e_ip    = 1'b0;
      e_line  = 3'd0;
      if (!rst) begin
         if (m_phase == 0) begin
            if (exception_type_i != 0) e_stall = 6'h3f;
            else if (stallreq_ex_i)    e_stall = 6'h0f;
            else if (stallreq_id_i)    e_stall = 6'h07;
         end
         e_ip = (pend != 0) && cp0_status_i[0] && !cp0_status_i[1];
         for (int b = 0; b < 8; b++) if (pend[b]) e_line = 3'(b);
      end
      chk("m_stall",   32'(stall_o),         32'(e_stall));
      chk("m_flush",   32'(flush_o),         32'(m_phase == 1));
      chk("m_new_pc",  new_pc_o,             (m_phase == 1) ? m_tgt : 32'd0);
      chk("m_int_pnd", 32'(int_pending_o),   32'(e_ip));
      chk("m_int_ln",  32'(int_line_o),      32'(e_line));
      chk("m_timeout", 32'(stall_timeout_o), 32'(m_sticky || (m_run == 64)));
   endtask

   task automatic model_edge();
      if (rst) begin
         m_phase = 0; m_tgt = 0; m_run = 0; m_sticky = 0;
      end else begin
         if (m_run == 64) m_sticky = 1;
         if (m_phase == 0 && exception_type_i == 0 && (stallreq_ex_i || stallreq_id_i))
            m_run = (m_run >= 255) ? 255 : m_run + 1;
         else
            m_run = 0;
         if (m_phase == 0) begin
            if (exception_type_i != 0) begin
               m_phase = 1;
               m_tgt   = (exception_type_i == 32'he) ? cp0_epc_i : 32'h20;
            end
         end else if (m_phase == 1) m_phase = 2;
         else m_phase = 0;
      end
   endtask

   task automatic step(input logic r, input logic id, input logic ex, input logic [31:0] exc,
                       input logic [31:0] st, input logic [31:0] ca, input logic [31:0] epc);
      @(posedge clk);
      #1;
      rst = r; stallreq_id_i = id; stallreq_ex_i = ex; exception_type_i = exc;
      cp0_status_i = st; cp0_cause_i = ca; cp0_epc_i = epc;
      @(negedge clk);
      model_check();
      model_edge();
   endtask

   vec_t vecs[29];

   initial begin
      rst = 1; stallreq_id_i = 0; stallreq_ex_i = 0; exception_type_i = 0;
      cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0;
      m_phase = 0; m_tgt = 0; m_run = 0; m_sticky = 0;

      //            rst id ex exc     status        cause         epc          stall  fl pc           ip line
      vecs[0]  = '{1, 1, 1, 32'h8, 32'h8401, 32'h8400, 32'h0,    6'h00, 0, 32'h0,    0, 0};
      vecs[1]  = '{0, 0, 0, 32'h8, 32'h0,    32'h0,    32'h0,    6'h3f, 0, 32'h0,    0, 0};
      vecs[2]  = '{0, 0, 0, 32'h0, 32'h0,    32'h0,    32'h0,    6'h00, 1, 32'h20,   0, 0};
      vecs[3]  = '{0, 0, 0, 32'h0, 32'h0,    32'h0,    32'h0,    6'h00, 0, 32'h0,    0, 0};
      vecs[4]  = '{0, 0, 0, 32'he, 32'h0,    32'h0,    32'h1234, 6'h3f, 0, 32'h0,    0, 0};
      vecs[5]  = '{0, 0, 0, 32'h0, 32'h0,    32'h0,    32'h0,    6'h00, 1, 32'h1234, 0, 0};
      vecs[6]  = '{0, 0, 0, 32'h0, 32'h0,    32'h0,    32'h0,    6'h00, 0, 32'h0,    0, 0};
      vecs[7]  = '{0, 0, 0, 32'ha, 32'h0,    32'h0,    32'h0,    6'h3f, 0, 32'h0,    0, 0};
      vecs[8]  = '{0, 0, 0, 32'ha, 32'h0,    32'h0,    32'h0,    6'h00, 1, 32'h20,   0, 0};
      vecs[9]  = '{0, 0, 0, 32'ha, 32'h0,    32'h0,    32'h0,    6'h00, 0, 32'h0,    0, 0};
      vecs[10] = '{0, 0, 0, 32'h0, 32'h0,    32'h0,    32'h0,    6'h00, 0, 32'h0,    0, 0};
      vecs[11] = '{0, 0, 0, 32'hd, 32'h0,    32'h0,    32'h0,    6'h3f, 0, 32'h0,    0, 0};
      vecs[12] = '{0, 0, 0, 32'hd, 32'h0,    32'h0,    32'h0,    6'h00, 1, 32'h20,   0, 0};
      vecs[13] = '{0, 0, 0, 32'hd, 32'h0,    32'h0,    32'h0,    6'h00, 0, 32'h0,    0, 0};
      vecs[14] = '{0, 0, 0, 32'he, 32'h0,    32'h0,    32'h5678, 6'h3f, 0, 32'h0,    0, 0};
      vecs[15] = '{0, 0, 0, 32'h0, 32'h0,    32'h0,    32'h0,    6'h00, 1, 32'h5678, 0, 0};
      vecs[16] = '{0, 0, 0, 32'h0, 32'h0,    32'h0,    32'h0,    6'h00, 0, 32'h0,    0, 0};
      vecs[17] = '{0, 0, 0, 32'h0, 32'h0,    32'h0,    32'h0,    6'h00, 0, 32'h0,    0, 0};
      vecs[18] = '{0, 1, 1, 32'h0, 32'h0,    32'h0,    32'h0,    6'h0f, 0, 32'h0,    0, 0};
      vecs[19] = '{0, 1, 0, 32'h0, 32'h0,    32'h0,    32'h0,    6'h07, 0, 32'h0,    0, 0};
      vecs[20] = '{0, 0, 1, 32'h0, 32'h0,    32'h0,    32'h0,    6'h0f, 0, 32'h0,    0, 0};
      vecs[21] = '{0, 0, 0, 32'h0, 32'h0,    32'h0,    32'h0,    6'h00, 0, 32'h0,    0, 0};
      vecs[22] = '{0, 0, 0, 32'h0, 32'h8401, 32'h8400, 32'h0,    6'h00, 0, 32'h0,    1, 7};
      vecs[23] = '{0, 0, 0, 32'h0, 32'h8403, 32'h8400, 32'h0,    6'h00, 0, 32'h0,    0, 7};
      vecs[24] = '{0, 0, 0, 32'h0, 32'h0101, 32'h0100, 32'h0,    6'h00, 0, 32'h0,    1, 0};
      vecs[25] = '{0, 0, 0, 32'h0, 32'hff01, 32'h0,    32'h0,    6'h00, 0, 32'h0,    0, 0};
      vecs[26] = '{0, 0, 0, 32'hc, 32'h0,    32'h0,    32'h0,    6'h3f, 0, 32'h0,    0, 0};
      vecs[27] = '{1, 1, 0, 32'h8, 32'h0,    32'h0,    32'h0,    6'h00, 1, 32'h20,   0, 0};
      vecs[28] = '{0, 0, 0, 32'h0, 32'h0,    32'h0,    32'h0,    6'h00, 0, 32'h0,    0, 0};

      step(1, 0, 0, 0, 0, 0, 0);
      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].id, vecs[i].ex, vecs[i].exc,
              vecs[i].status, vecs[i].cause, vecs[i].epc);
         chk($sformatf("v%0d_stall", i), 32'(stall_o),       32'(vecs[i].e_stall));
         chk($sformatf("v%0d_flush", i), 32'(flush_o),       32'(vecs[i].e_flush));
         chk($sformatf("v%0d_pc", i),    new_pc_o,           vecs[i].e_pc);
         chk($sformatf("v%0d_ip", i),    32'(int_pending_o), 32'(vecs[i].e_ip));
         chk($sformatf("v%0d_line", i),  32'(int_line_o),    32'(vecs[i].e_line));
      end

      // watchdog: 64 consecutive EX stalls, flag sticks after the stall drops, reset clears it
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 64; i++) begin
         step(0, 0, 1, 0, 0, 0, 0);
         chk("wd_early", 32'(stall_timeout_o), 32'd0);
      end
      step(0, 0, 0, 0, 0, 0, 0);
      chk("wd_set", 32'(stall_timeout_o), 32'd1);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("wd_sticky", 32'(stall_timeout_o), 32'd1);
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("wd_reset", 32'(stall_timeout_o), 32'd0);

      // randomized traffic, including long EX bursts and occasional resets
      for (int i = 0; i < 1500; i++) begin
         logic [31:0] exc;
         logic        ex;
         case ($urandom_range(0, 11))
            0: exc = 32'h1;
            1: exc = 32'h8;
            2: exc = 32'he;
            3: exc = $urandom;
            default: exc = 32'h0;
         endcase
         if ($urandom_range(0, 3) != 0) exc = 32'h0;
         ex = (i % 300 < 120) ? ($urandom_range(0, 30) != 0) : ($urandom_range(0, 2) == 0);
         step(($urandom_range(0, 80) == 0), 1'($urandom_range(0, 1)), ex, exc,
              $urandom, $urandom, $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'h0000_0020, meaning the handler entry PC for all non-eret exceptions.
REQ-002 SHALL have parameter STALL_MAX, default 8'd64, meaning the consecutive-stall count that raises the stall timeout.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1, the reset; synchronous, active-high (`RstEnable).
REQ-005 SHALL have port stallreq_id_i, input, 1, ID-stage stall request.
REQ-006 SHALL have port stallreq_ex_i, input, 1, EX-stage stall request.
REQ-007 SHALL have port exception_type_i, input, 32, final MEM-stage exception type; 0 means none.
REQ-008 SHALL have port cp0_status_i, input, 32, forwarded CP0 Status.
REQ-009 SHALL have port cp0_cause_i, input, 32, forwarded CP0 Cause.
REQ-010 SHALL have port cp0_epc_i, input, 32, forwarded CP0 EPC.
REQ-011 SHALL have port stall_o, output, 6, per-stage stall vector {wb,mem,ex,id,if,pc} as bits [5:0].
REQ-012 SHALL have port flush_o, output, 1, pipeline flush pulse.
REQ-013 SHALL have port new_pc_o, output, 32, redirect PC; valid only while flush_o=1.
REQ-014 SHALL have port int_pending_o, output, 1, an enabled interrupt is pending.
REQ-015 SHALL have port int_line_o, output, 3, index of the highest pending enabled interrupt line.
REQ-016 SHALL have port stall_timeout_o, output, 1, sticky stall watchdog flag.

Function
REQ-017 SHALL implement FSM states IDLE, FLUSH, HOLD; IDLE->FLUSH when exception_type_i!=0; FLUSH->HOLD unconditionally; HOLD->IDLE unconditionally.
REQ-018 SHALL recognise types 32'h1 int, 32'h8 syscall, 32'ha invalid inst, 32'hd trap, 32'hc overflow, 32'he eret; any other nonzero value SHALL be handled as a non-eret exception.
REQ-019 SHALL, in IDLE with exception_type_i!=0, drive stall_o=6'b111111 combinationally in that cycle and latch the target: cp0_epc_i if type==32'he, else EXC_VECTOR.
REQ-020 SHALL drive flush_o=1 and new_pc_o=latched target for exactly the one cycle in FLUSH (latency 1 cycle from detection); flush_o=0 and new_pc_o=0 otherwise.
REQ-021 SHALL ignore exception_type_i in FLUSH and HOLD; stall_o=0 in both states.
REQ-022 SHALL in IDLE with no exception drive stall_o=6'b001111 if stallreq_ex_i, else 6'b000111 if stallreq_id_i, else 0; EX has priority when both are requested.
REQ-023 SHALL compute pending = cp0_cause_i[15:8] & cp0_status_i[15:8] combinationally.
REQ-024 SHALL drive int_pending_o = (|pending) & cp0_status_i[0] & ~cp0_status_i[1].
REQ-025 SHALL drive int_line_o = highest set bit index of pending (bit 15 -> 7, bit 8 -> 0); 0 when pending==0.
REQ-026 SHALL keep an 8-bit counter incremented each cycle in IDLE with nonzero stall_o from REQ-022, saturating at 255, cleared on any cycle with a zero REQ-022 stall and on entry to FLUSH.
REQ-027 SHALL set stall_timeout_o when the counter equals STALL_MAX; it stays 1 until reset.

Reset
REQ-028 SHALL on rst=1 at a clock edge force IDLE, clear the counter and latched target, and clear stall_timeout_o; flush_o=0, new_pc_o=0.
REQ-029 SHALL, while rst=1, drive stall_o=0, int_pending_o=0, int_line_o=0, regardless of inputs.
REQ-030 SHALL on rst asserted during FLUSH or HOLD abandon the sequence; no flush_o pulse after the reset edge.

Verification
REQ-031 SHALL test syscall: exception_type_i=32'h8 for 1 cycle in IDLE -> stall_o=6'h3f that cycle; next cycle flush_o=1, new_pc_o=32'h20; the following cycle flush_o=0.
REQ-032 SHALL test eret: cp0_epc_i=32'h0000_1234, type=32'he -> next cycle flush_o=1, new_pc_o=32'h0000_1234.
REQ-033 SHALL test back-to-back exceptions: type=32'ha held for 3 cycles -> exactly one flush_o pulse; re-detection only on the cycle after HOLD.
REQ-034 SHALL test stall priority: stallreq_id_i=stallreq_ex_i=1 -> stall_o=6'b001111; only stallreq_id_i=1 -> 6'b000111.
REQ-035 SHALL test interrupts: status=32'h0000_8401, cause[15:8]=8'h84 -> int_pending_o=1, int_line_o=7; set status[1]=1 -> int_pending_o=0.
REQ-036 SHALL test watchdog: stallreq_ex_i=1 for 64 cycles -> stall_timeout_o=1, still 1 after the stall drops; rst -> 0.
